// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU (opcodes 0..13) with valid/ready handshakes, tag passthrough and flags.
// Optional ALU_SAT_EN: add/increment/addTwo saturate high, decrements saturate at zero.
module alu_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_err,
    output logic             cond_out
);
    localparam int unsigned SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0] ONE_X = {1'b0, ONE};
    localparam logic [WIDTH:0] TWO_X = {1'b0, ONE} << 1;

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic             s2_free;
    logic             s1_move;

    assign s2_free   = !s2_valid || out_ready;
    assign s1_move   = s1_valid && s2_free;
    assign in_ready  = !s1_valid || s1_move;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                s1_op  <= in_op;
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_tag <= in_tag;
            end
        end
    end

    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             err_c;
    logic             cond_c;
    logic [WIDTH:0]   sum_c;
    logic             is_arith;
    logic             is_dec;
    logic [SH_W-1:0]  sh;

    always_comb begin
        res_c    = '0;
        carry_c  = 1'b0;
        err_c    = 1'b0;
        cond_c   = cond_out;
        sum_c    = '0;
        is_arith = 1'b0;
        is_dec   = 1'b0;
        sh       = s1_b[SH_W-1:0];
        case (s1_op)
            4'd0:  res_c = s1_a;
            4'd1:  res_c = (s1_a >= s1_b) ? s1_a - s1_b : s1_b - s1_a;
            4'd2:  res_c = s1_a >> 1;
            4'd3:  res_c = ONE << sh;
            4'd4:  res_c = (ONE << sh) - ONE;
            4'd5: begin
                res_c  = {{(WIDTH - 1){1'b0}}, s1_a == s1_b};
                cond_c = (s1_a == s1_b);
            end
            4'd6: begin
                sum_c    = {1'b0, s1_a} + {1'b0, s1_b};
                is_arith = 1'b1;
            end
            4'd7: begin
                sum_c    = {1'b0, s1_a} + ONE_X;
                is_arith = 1'b1;
            end
            4'd8: begin
                res_c  = s1_a;
                cond_c = s1_a[WIDTH-1];
            end
            4'd9: begin
                res_c   = s1_a << 1;
                carry_c = s1_a[WIDTH-1];
            end
            4'd10: res_c = (s1_a < s1_b) ? s1_a : s1_b;
            4'd11, 4'd12: begin
                // Bit WIDTH of the widened difference is the borrow.
                sum_c    = {1'b0, s1_a} - ONE_X;
                is_arith = 1'b1;
                is_dec   = 1'b1;
                cond_c   = (s1_op == 4'd12);
            end
            4'd13: begin
                sum_c    = {1'b0, s1_a} + TWO_X;
                is_arith = 1'b1;
            end
            default: err_c = 1'b1;
        endcase
        if (is_arith) begin
            res_c   = sum_c[WIDTH-1:0];
            carry_c = sum_c[WIDTH];
`ifdef ALU_SAT_EN
            if (carry_c) res_c = is_dec ? '0 : '1;
`else
            if (carry_c && is_dec) res_c = sum_c[WIDTH-1:0];
`endif
        end
    end

    // Output registers only load when S1 hands over, so they hold under back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
            out_zero  <= 1'b0;
            out_carry <= 1'b0;
            out_err   <= 1'b0;
            cond_out  <= 1'b0;
        end else begin
            if (s2_free) s2_valid <= s1_valid;
            if (s1_move) begin
                out_res   <= res_c;
                out_tag   <= s1_tag;
                out_zero  <= (res_c == '0);
                out_carry <= carry_c;
                out_err   <= err_c;
                cond_out  <= cond_c;
            end
        end
    end

endmodule
